// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_gen_pkg;

  localparam int unsigned REG_LEN     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    PcBoot,
    PcRun,
    PcSquash
  } pc_state_e;

endpackage

// File: rtl/pc_gen.sv
// Program-counter sequencer: boot wait, +4 advance, stall hold, redirect, and squash
// window covering the instructions already in flight downstream.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [REG_LEN-1:0] ResetVector = 32'h0000_0000,
  parameter int unsigned        FlushCycles = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [REG_LEN-1:0] target_i,
  output logic [REG_LEN-1:0] pc_o,
  output logic               pc_valid_o,
  output logic               flush_o,
  output logic               misaligned_o
);

  pc_state_e          state_q, state_d;
  logic [REG_LEN-1:0] pc_q, pc_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               flush_q, flush_d;
  logic               mis_q, mis_d;
  logic [REG_LEN-1:0] pc_inc;

  assign pc_inc = pc_q + REG_LEN'(INSTR_BYTES);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    flush_d = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      PcBoot: begin
        // Covers the synchronous imem read latency; inputs are ignored here.
        state_d = PcRun;
        valid_d = 1'b1;
      end
      PcRun, PcSquash: begin
        if (redirect_i) begin
          state_d = PcSquash;
          pc_d    = {target_i[REG_LEN-1:2], 2'b00};
          cnt_d   = 3'(FlushCycles);
          flush_d = 1'b1;
          mis_d   = |target_i[1:0];
        end else if (state_q == PcRun) begin
          if (!stall_i) begin
            pc_d    = pc_inc;
            valid_d = 1'b1;
          end
        end else begin
          flush_d = 1'b1;
          if (!stall_i) begin
            pc_d  = pc_inc;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
              state_d = PcRun;
              valid_d = 1'b1;
              flush_d = 1'b0;
            end
          end
        end
      end
      default: state_d = PcBoot;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PcBoot;
      pc_q    <= ResetVector;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_o         = pc_q;
  assign pc_valid_o   = valid_q;
  assign flush_o      = flush_q;
  assign misaligned_o = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot, advance, redirect/squash, stall, wrap, async reset.
module tb_pc_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] target_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        flush_o;
  logic        misaligned_o;

  int n_checks = 0;
  int n_fails  = 0;

  pc_gen dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .stall_i     (stall_i),
    .redirect_i  (redirect_i),
    .target_i    (target_i),
    .pc_o        (pc_o),
    .pc_valid_o  (pc_valid_o),
    .flush_o     (flush_o),
    .misaligned_o(misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic valid,
                         input logic flush, input logic mis);
    check({tag, ".pc"}, pc_o, pc);
    check({tag, ".valid"}, 32'(pc_valid_o), 32'(valid));
    check({tag, ".flush"}, 32'(flush_o), 32'(flush));
    check({tag, ".mis"}, 32'(misaligned_o), 32'(mis));
  endtask

  // Advance one edge and settle before sampling / driving.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_i = 1'b1;
    target_i   = t;
  endtask

  initial begin
    rst_ni     = 1'b0;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    target_i   = '0;
    #1;
    chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    rst_ni = 1'b1;

    // 1: boot cycle then sequential fetch
    chk_out("boot", 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(); chk_out("run0", 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(); chk_out("run4", 32'h4, 1'b1, 1'b0, 1'b0);
    cycle(); chk_out("run8", 32'h8, 1'b1, 1'b0, 1'b0);
    cycle(); chk_out("runC", 32'hC, 1'b1, 1'b0, 1'b0);
    cycle(); chk_out("run10", 32'h10, 1'b1, 1'b0, 1'b0);

    // 2: aligned redirect
    redir(32'h100);
    cycle(); chk_out("br100", 32'h100, 1'b0, 1'b1, 1'b0);
    redirect_i = 1'b0;
    cycle(); chk_out("sq104", 32'h104, 1'b0, 1'b1, 1'b0);
    cycle(); chk_out("run108", 32'h108, 1'b1, 1'b0, 1'b0);

    // 3: misaligned redirect
    redir(32'h203);
    cycle(); chk_out("br203", 32'h200, 1'b0, 1'b1, 1'b1);
    redirect_i = 1'b0;
    cycle(); chk_out("sq204", 32'h204, 1'b0, 1'b1, 1'b0);
    cycle(); chk_out("run208", 32'h208, 1'b1, 1'b0, 1'b0);

    // 4: stall freezes squash at cnt=1
    redir(32'h300);
    cycle(); chk_out("br300", 32'h300, 1'b0, 1'b1, 1'b0);
    redirect_i = 1'b0;
    cycle(); chk_out("sq304", 32'h304, 1'b0, 1'b1, 1'b0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(); chk_out($sformatf("sqstall%0d", i), 32'h304, 1'b0, 1'b1, 1'b0);
    end
    stall_i = 1'b0;
    cycle(); chk_out("run308", 32'h308, 1'b1, 1'b0, 1'b0);

    // redirect inside squash restarts the count
    redir(32'h400);
    cycle(); chk_out("br400", 32'h400, 1'b0, 1'b1, 1'b0);
    redirect_i = 1'b0;
    cycle(); chk_out("sq404", 32'h404, 1'b0, 1'b1, 1'b0);
    redir(32'h500);
    cycle(); chk_out("rebr500", 32'h500, 1'b0, 1'b1, 1'b0);
    redirect_i = 1'b0;
    cycle(); chk_out("sq504", 32'h504, 1'b0, 1'b1, 1'b0);
    cycle(); chk_out("run508", 32'h508, 1'b1, 1'b0, 1'b0);

    // RUN stall, then stall+redirect: redirect wins
    stall_i = 1'b1;
    cycle(); chk_out("stall508", 32'h508, 1'b0, 1'b0, 1'b0);
    redir(32'h600);
    cycle(); chk_out("stallbr600", 32'h600, 1'b0, 1'b1, 1'b0);
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    cycle(); chk_out("sq604", 32'h604, 1'b0, 1'b1, 1'b0);
    cycle(); chk_out("run608", 32'h608, 1'b1, 1'b0, 1'b0);

    // 5: address wrap
    redir(32'hFFFF_FFF0);
    cycle(); chk_out("brFFF0", 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0);
    redirect_i = 1'b0;
    cycle(); chk_out("sqFFF4", 32'hFFFF_FFF4, 1'b0, 1'b1, 1'b0);
    cycle(); chk_out("runFFF8", 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
    cycle(); chk_out("runFFFC", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    cycle(); chk_out("wrap0", 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(); chk_out("wrap4", 32'h4, 1'b1, 1'b0, 1'b0);

    // 6: async reset mid-squash clears everything between edges
    redir(32'h703);
    cycle(); chk_out("br703", 32'h700, 1'b0, 1'b1, 1'b1);
    redirect_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk_out("asyncrst", 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(); chk_out("heldrst", 32'h0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;

    // redirect is ignored during BOOT, taken once in RUN
    redir(32'h800);
    cycle(); chk_out("bootign", 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(); chk_out("br800", 32'h800, 1'b0, 1'b1, 1'b0);
    redirect_i = 1'b0;
    cycle(); chk_out("sq804", 32'h804, 1'b0, 1'b1, 1'b0);
    cycle(); chk_out("run808", 32'h808, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
